wb_master: RTL and testbench

Wishbone classic single-transfer initiator that drives the team's Wishbone peripherals (UART register block and siblings) from a simple valid/ready command port. It serves as the bus-side front end for debug loaders, CPU stubs and test sequencers. Each accepted command becomes exactly one Wishbone read or write cycle. Read data, or a timeout error, is returned on a valid/ready response port.

---
 rtl/wb_master_pkg.sv | 30 +++
 rtl/wb_master.sv | 141 ++++++++++++++
 tb/tb_wb_master.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types and constants for Wishbone classic initiators.
// The FSM encoding is exported both as an enum and as plain constants.
package wb_master_pkg;

  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  typedef struct packed {
    logic                we;
    logic [31:0]         adr;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_DAT_W-1:0] dat;
  } wb_cmd_t;

  typedef struct packed {
    logic [WB_DAT_W-1:0] dat;
    logic                err;
  } wb_rsp_t;

endpackage

// File: rtl/wb_master.sv
// Wishbone classic single-transfer initiator: one command in, one bus cycle,
// one response (read data or timeout error) out.
module wb_master
  import wb_master_pkg::*;
#(
  parameter int ADR_W   = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADR_W-1:0]    cmd_adr_i,
  input  logic [WB_SEL_W-1:0] cmd_sel_i,
  input  logic [WB_DAT_W-1:0] cmd_dat_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [WB_DAT_W-1:0] rsp_dat_o,
  output logic                rsp_err_o,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [ADR_W-1:0]    adr_o,
  output logic [WB_SEL_W-1:0] sel_o,
  output logic [WB_DAT_W-1:0] dat_o,
  input  logic [WB_DAT_W-1:0] dat_i,
  input  logic                ack_i
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_cmd_ready;
  logic                r_rsp_valid;
  logic                r_stb;
  logic                r_we;
  logic [ADR_W-1:0]    r_adr;
  logic [WB_SEL_W-1:0] r_sel;
  logic [WB_DAT_W-1:0] r_dat;
  logic [WB_DAT_W-1:0] r_rsp_dat;
  logic                r_rsp_err;
  logic                w_accept;
  logic                w_bus_ack;
  logic                w_bus_expire;

  // r_cmd_ready stays low until the first edge after reset release.
  assign w_accept     = (r_state == ST_IDLE) & r_cmd_ready & cmd_valid_i;
  assign w_bus_ack    = (r_state == ST_BUS) & ack_i;
  assign w_bus_expire = (r_state == ST_BUS) & ~ack_i & (r_cnt == CNT_LAST);

  // Next-state logic: ack takes priority over timeout expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_BUS;
        else          w_state_nxt = ST_IDLE;
      end
      ST_BUS: begin
        if (w_bus_ack || w_bus_expire) w_state_nxt = ST_RESP;
        else                           w_state_nxt = ST_BUS;
      end
      ST_RESP: begin
        if (rsp_ready_i) w_state_nxt = ST_IDLE;
        else             w_state_nxt = ST_RESP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register and registered decodes of the next state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_stb       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_stb       <= (w_state_nxt == ST_BUS);
    end
  end

  // Bus request capture and saturating timeout counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we  <= 1'b0;
      r_adr <= {ADR_W{1'b0}};
      r_sel <= {WB_SEL_W{1'b0}};
      r_dat <= {WB_DAT_W{1'b0}};
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_accept) begin
      r_we  <= cmd_we_i;
      r_adr <= cmd_adr_i;
      r_sel <= cmd_sel_i;
      r_dat <= cmd_dat_i;
      r_cnt <= {CNT_W{1'b0}};
    end else if ((r_state == ST_BUS) && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Response capture; dat_i is only looked at in the ack cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rsp_dat <= {WB_DAT_W{1'b0}};
      r_rsp_err <= 1'b0;
    end else if (w_bus_ack) begin
      r_rsp_dat <= r_we ? {WB_DAT_W{1'b0}} : dat_i;
      r_rsp_err <= 1'b0;
    end else if (w_bus_expire) begin
      r_rsp_dat <= {WB_DAT_W{1'b0}};
      r_rsp_err <= 1'b1;
    end else begin
      r_rsp_dat <= r_rsp_dat;
      r_rsp_err <= r_rsp_err;
    end
  end

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign cyc_o       = r_stb;
  assign stb_o       = r_stb;
  assign we_o        = r_we;
  assign adr_o       = r_adr;
  assign sel_o       = r_sel;
  assign dat_o       = r_dat;

endmodule

// File: tb/tb_wb_master.sv
// Self-checking bench for wb_master against a word-memory responder with
// programmable wait states and a transfer-level reference model.
module tb_wb_master;
  import wb_master_pkg::*;

  localparam int ADR_W = 2;
  localparam int TO    = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_we_i = 1'b0;
  logic [1:0]  cmd_adr_i = 2'd0;
  logic [3:0]  cmd_sel_i = 4'h0;
  logic [31:0] cmd_dat_i = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        cyc_o, stb_o, we_o;
  logic [1:0]  adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  wb_master #(.ADR_W(ADR_W), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o),
    .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;

  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    return r;
  endfunction

  // Responder: acks after wait_cfg wait states (never when negative).
  int          wait_cfg = 0;
  logic        stray = 1'b0;
  logic        mem_clr = 1'b1;
  int          stb_cnt = 0;
  logic [31:0] slv_mem [4];

  always @(posedge clk_i) begin
    if (!stb_o) stb_cnt <= 0;
    else        stb_cnt <= stb_cnt + 1;
    if (mem_clr) begin
      for (int i = 0; i < 4; i++) slv_mem[i] <= 32'h0;
    end else if (ack_i && stb_o && we_o) begin
      slv_mem[adr_o] <= merge(slv_mem[adr_o], dat_o, sel_o);
    end
  end

  assign ack_i = stray | (stb_o && (wait_cfg >= 0) && (stb_cnt == wait_cfg));
  assign dat_i = ack_i ? slv_mem[adr_o] : (32'hBAD0_0000 ^ 32'(stb_cnt));

  logic [31:0] ref_mem [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transfer; w = wait states (<0: never ack), bp = response stall cycles.
  task automatic xfer(input logic we, input logic [1:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int w, input int bp, input logic bp_stray,
                      output int acc_cyc);
    int n;
    int guard;
    int exp_stb;
    logic exp_err;
    logic [31:0] exp_dat;
    wait_cfg = w;
    cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
    cmd_valid_i = 1'b1;
    guard = 0;
    while (!cmd_ready_o && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    chk("cmd_ready_wait", {31'b0, cmd_ready_o}, 32'd1);
    @(posedge clk_i);
    @(negedge clk_i);
    acc_cyc = cyc_cnt;
    cmd_valid_i = 1'b0;
    if (w >= 0 && w < TO) begin exp_stb = w + 1; exp_err = 1'b0; end
    else begin exp_stb = TO; exp_err = 1'b1; end
    exp_dat = (exp_err || we) ? 32'h0 : ref_mem[adr];
    if (!exp_err && we) ref_mem[adr] = merge(ref_mem[adr], dat, sel);
    n = 0;
    while (stb_o && n < 100) begin
      n++;
      chk("bus_cyc", {31'b0, cyc_o}, 32'd1);
      chk("bus_we", {31'b0, we_o}, {31'b0, we});
      chk("bus_adr", {30'b0, adr_o}, {30'b0, adr});
      chk("bus_sel", {28'b0, sel_o}, {28'b0, sel});
      chk("bus_dat", dat_o, dat);
      @(negedge clk_i);
    end
    chk("stb_cycles", 32'(n), 32'(exp_stb));
    chk("rsp_valid", {31'b0, rsp_valid_o}, 32'd1);
    chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
    chk("rsp_dat", rsp_dat_o, exp_dat);
    chk("ready_in_resp", {31'b0, cmd_ready_o}, 32'd0);
    for (int i = 0; i < bp; i++) begin
      cmd_valid_i = 1'b1;
      stray = bp_stray;
      @(negedge clk_i);
      chk("bp_valid", {31'b0, rsp_valid_o}, 32'd1);
      chk("bp_dat", rsp_dat_o, exp_dat);
      chk("bp_err", {31'b0, rsp_err_o}, {31'b0, exp_err});
      chk("bp_ready", {31'b0, cmd_ready_o}, 32'd0);
      chk("bp_stb", {31'b0, stb_o}, 32'd0);
    end
    cmd_valid_i = 1'b0;
    stray = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("ready_after_consume", {31'b0, cmd_ready_o}, 32'd1);
    chk("valid_after_consume", {31'b0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    int t0, t1, t2, t3;
    logic we_r;
    int w_r;
    for (int i = 0; i < 4; i++) ref_mem[i] = 32'h0;

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {31'b0, cmd_ready_o}, 32'd0);
    chk("rst_stb", {30'b0, cyc_o, stb_o}, 32'd0);
    chk("rst_rsp", {30'b0, rsp_valid_o, rsp_err_o}, 32'd0);
    chk("rst_rsp_dat", rsp_dat_o, 32'h0);
    chk("rst_bus", {we_o, adr_o, sel_o} ^ dat_o, 32'h0);
    mem_clr = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("ready_after_release", {31'b0, cmd_ready_o}, 32'd1);

    // Zero-wait write, then a read with 3 wait states
    xfer(1'b1, 2'd1, 4'hF, 32'h0000_0041, 0, 0, 1'b0, t0);
    xfer(1'b1, 2'd2, 4'hF, 32'hDEAD_BEEF, 0, 0, 1'b0, t0);
    xfer(1'b0, 2'd2, 4'hF, 32'h0, 3, 0, 1'b0, t0);
    xfer(1'b0, 2'd1, 4'hF, 32'h0, 0, 0, 1'b0, t0);

    // Timeout, ack in the last allowed cycle, and a write that times out
    xfer(1'b0, 2'd2, 4'hF, 32'h0, -1, 0, 1'b0, t0);
    xfer(1'b0, 2'd2, 4'hF, 32'h0, TO - 1, 0, 1'b0, t0);
    xfer(1'b1, 2'd2, 4'hF, 32'h1234_5678, TO, 0, 1'b0, t0);
    xfer(1'b0, 2'd2, 4'hF, 32'h0, 1, 0, 1'b0, t0);

    // Response backpressure with a pending command
    xfer(1'b0, 2'd1, 4'hF, 32'h0, 1, 5, 1'b0, t0);

    // Stray acks in IDLE and RESP
    stray = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      chk("stray_idle_stb", {31'b0, stb_o}, 32'd0);
      chk("stray_idle_rsp", {31'b0, rsp_valid_o}, 32'd0);
      chk("stray_idle_ready", {31'b0, cmd_ready_o}, 32'd1);
    end
    stray = 1'b0;
    xfer(1'b1, 2'd0, 4'h5, 32'hA1B2_C3D4, 2, 2, 1'b1, t0);

    // Three back-to-back reads
    xfer(1'b0, 2'd0, 4'hF, 32'h0, 0, 0, 1'b0, t1);
    xfer(1'b0, 2'd1, 4'hF, 32'h0, 0, 0, 1'b0, t2);
    xfer(1'b0, 2'd2, 4'hF, 32'h0, 0, 0, 1'b0, t3);
    chk("b2b_gap1", 32'(t2 - t1), 32'd3);
    chk("b2b_gap2", 32'(t3 - t2), 32'd3);

    // Reset in the middle of a bus cycle
    wait_cfg = -1;
    cmd_we_i = 1'b0; cmd_adr_i = 2'd1; cmd_sel_i = 4'hF;
    cmd_valid_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mid_stb_before", {31'b0, stb_o}, 32'd1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_bus", {29'b0, cyc_o, stb_o, rsp_valid_o}, 32'd0);
    chk("mid_rst_ready", {31'b0, cmd_ready_o}, 32'd0);
    chk("mid_rst_adr", {27'b0, we_o, adr_o, rsp_err_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("mid_rel_ready", {31'b0, cmd_ready_o}, 32'd1);
    chk("mid_rel_valid", {31'b0, rsp_valid_o}, 32'd0);
    xfer(1'b0, 2'd2, 4'hF, 32'h0, 2, 0, 1'b0, t0);

    // Randomized transfers
    for (int k = 0; k < 25; k++) begin
      we_r = 1'($urandom_range(0, 1));
      w_r  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 10));
      xfer(we_r, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
           w_r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), t0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
